gshare_predictor: RTL and testbench

Parametrised global-history branch direction predictor for the fetch stage. It is the successor to the fixed-concatenation history predictor, and adds four things: a selectable PC/history hash, a speculative global history register (GHR) with per-branch checkpoints, saturating counters of arbitrary width, and a post-reset table-initialisation sweep. It gives a taken/not-taken prediction in the same cycle the PC is presented, and is trained and repaired by branch resolution in EX.

---
 rtl/gshare_predictor_if.sv | 33 +++
 rtl/gshare_predictor.sv | 106 ++++++++++
 tb/tb_gshare_predictor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and EX-side resolution signals of the gshare predictor.
// The predictor binds to the slave modport; the fetch/EX side uses master.
interface gshare_predictor_if #(
    parameter int CNT_WIDTH   = 2,
    parameter int INDEX_WIDTH = 12,
    parameter int GHR_WIDTH   = 8
);
    logic                   stall;
    logic                   pred_valid;
    logic [31:0]            pc;
    logic                   pred_taken;
    logic [CNT_WIDTH-1:0]   pred_count;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic [GHR_WIDTH-1:0]   pred_ghr;
    logic                   ready;
    logic                   res_valid;
    logic [INDEX_WIDTH-1:0] res_index;
    logic [GHR_WIDTH-1:0]   res_ghr;
    logic                   res_taken;
    logic                   res_mispredict;

    modport master (
        output stall, pred_valid, pc,
        output res_valid, res_index, res_ghr, res_taken, res_mispredict,
        input  pred_taken, pred_count, pred_index, pred_ghr, ready
    );

    modport slave (
        input  stall, pred_valid, pc,
        input  res_valid, res_index, res_ghr, res_taken, res_mispredict,
        output pred_taken, pred_count, pred_index, pred_ghr, ready
    );
endinterface

// File: rtl/gshare_predictor.sv
// Global-history branch direction predictor: hashed PC/GHR index into a table of
// saturating counters, speculative GHR with repair, and a post-reset init sweep.
//
// state   | meaning
// ST_INIT | sweep writes CNT_INIT to entry ptr each cycle, outputs forced, res_* ignored
// ST_RUN  | predictions valid, training and GHR updates enabled
module gshare_predictor #(
    parameter int CNT_WIDTH   = 2,
    parameter int CNT_INIT    = 1,
    parameter int INDEX_WIDTH = 12,
    parameter int GHR_WIDTH   = 8,
    parameter int HASH_MODE   = 1
) (
    input logic              clk,
    input logic              rst_n,
    gshare_predictor_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0]   CNT_INIT_V = CNT_WIDTH'(CNT_INIT);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = '1;
    localparam logic [INDEX_WIDTH-1:0] PTR_LAST   = INDEX_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state, state_next;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [GHR_WIDTH-1:0]   ghr, ghr_next;
    logic [CNT_WIDTH-1:0]   cnt_table [DEPTH];

    logic                   ready_i;
    logic [INDEX_WIDTH-1:0] index;
    logic [CNT_WIDTH-1:0]   raw_count;
    logic                   raw_taken;
    logic [CNT_WIDTH-1:0]   cur_count, trained_count;
    logic                   unused_pc;

    generate
        if (HASH_MODE == 0) begin : g_concat
            assign index     = {bus.pc[INDEX_WIDTH-GHR_WIDTH+1:2], ghr};
            assign unused_pc = ^{bus.pc[31:INDEX_WIDTH-GHR_WIDTH+2], bus.pc[1:0]};
        end else begin : g_xor
            assign index     = bus.pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);
            assign unused_pc = ^{bus.pc[31:INDEX_WIDTH+2], bus.pc[1:0]};
        end
    endgenerate

    assign ready_i   = (state == ST_RUN);
    assign raw_count = cnt_table[index];
    assign raw_taken = raw_count[CNT_WIDTH-1];

    assign bus.ready      = ready_i;
    assign bus.pred_count = ready_i ? raw_count : CNT_INIT_V;
    assign bus.pred_taken = ready_i & raw_taken;
    assign bus.pred_index = ready_i ? index : '0;
    assign bus.pred_ghr   = ready_i ? ghr : '0;

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (ptr == PTR_LAST) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Repair wins over speculative advance: the speculative bit came from a wrong path.
    always_comb begin
        ghr_next = ghr;
        if (ready_i) begin
            if (bus.res_valid && bus.res_mispredict)
                ghr_next = GHR_WIDTH'({bus.res_ghr, bus.res_taken});
            else if (bus.pred_valid && !bus.stall)
                ghr_next = GHR_WIDTH'({ghr, raw_taken});
        end
    end

    always_comb begin
        cur_count     = cnt_table[bus.res_index];
        trained_count = cur_count;
        if (bus.res_taken) begin
            if (cur_count != CNT_MAX) trained_count = cur_count + CNT_WIDTH'(1);
        end else begin
            if (cur_count != '0) trained_count = cur_count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
            ghr   <= '0;
        end else begin
            state <= state_next;
            ghr   <= ghr_next;
            if (!ready_i) ptr <= ptr + INDEX_WIDTH'(1);
        end
    end

    // Table has no reset; the sweep owns its contents until ready rises.
    always_ff @(posedge clk) begin
        if (!ready_i)
            cnt_table[ptr] <= CNT_INIT_V;
        else if (bus.res_valid)
            cnt_table[bus.res_index] <= trained_count;
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed scenarios plus random traffic against a
// table/history model, with an XOR-hash and a concatenation-hash instance side by side.
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stall = 0, pred_valid = 0, res_valid = 0, res_taken = 0, res_mispredict = 0;
    logic [31:0] pc = 0;
    logic [3:0]  res_index = 0;
    logic [1:0]  res_ghr = 0;

    gshare_predictor_if #(.CNT_WIDTH(2), .INDEX_WIDTH(4), .GHR_WIDTH(2)) bus1 ();
    gshare_predictor_if #(.CNT_WIDTH(2), .INDEX_WIDTH(4), .GHR_WIDTH(2)) bus0 ();

    assign bus1.stall = stall;           assign bus0.stall = stall;
    assign bus1.pred_valid = pred_valid; assign bus0.pred_valid = pred_valid;
    assign bus1.pc = pc;                 assign bus0.pc = pc;
    assign bus1.res_valid = res_valid;   assign bus0.res_valid = res_valid;
    assign bus1.res_index = res_index;   assign bus0.res_index = res_index;
    assign bus1.res_ghr = res_ghr;       assign bus0.res_ghr = res_ghr;
    assign bus1.res_taken = res_taken;   assign bus0.res_taken = res_taken;
    assign bus1.res_mispredict = res_mispredict;
    assign bus0.res_mispredict = res_mispredict;

    gshare_predictor #(.CNT_WIDTH(2), .CNT_INIT(1), .INDEX_WIDTH(4), .GHR_WIDTH(2), .HASH_MODE(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    gshare_predictor #(.CNT_WIDTH(2), .CNT_INIT(1), .INDEX_WIDTH(4), .GHR_WIDTH(2), .HASH_MODE(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: both instances see the same writes, so one table serves both.
    int tbl [16];
    int ghr1, ghr0, edges;
    bit mready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_xor(input int g);
        return ((pc >> 2) % 16) ^ g;
    endfunction

    function automatic int idx_cat(input int g);
        return ((pc >> 2) % 4) * 4 + g;
    endfunction

    task automatic model_reset();
        ghr1 = 0; ghr0 = 0; edges = 0; mready = 0;
    endtask

    task automatic check_outputs();
        int i1, i0, c1, c0;
        i1 = mready ? idx_xor(ghr1) : 0;
        i0 = mready ? idx_cat(ghr0) : 0;
        c1 = mready ? tbl[i1] : 1;
        c0 = mready ? tbl[i0] : 1;
        chk("ready", bus1.ready, mready);
        chk("xor_index", bus1.pred_index, i1);
        chk("xor_ghr", bus1.pred_ghr, mready ? ghr1 : 0);
        chk("xor_count", bus1.pred_count, c1);
        chk("xor_taken", bus1.pred_taken, c1 >= 2);
        chk("cat_index", bus0.pred_index, i0);
        chk("cat_ghr", bus0.pred_ghr, mready ? ghr0 : 0);
        chk("cat_count", bus0.pred_count, c0);
    endtask

    task automatic model_edge();
        int pt1, pt0;
        if (!mready) begin
            tbl[edges] = 1;
            edges++;
            if (edges == 16) mready = 1;
            return;
        end
        pt1 = (tbl[idx_xor(ghr1)] >= 2) ? 1 : 0;
        pt0 = (tbl[idx_cat(ghr0)] >= 2) ? 1 : 0;
        if (res_valid) begin
            if (res_taken) tbl[res_index] = (tbl[res_index] < 3) ? tbl[res_index] + 1 : 3;
            else           tbl[res_index] = (tbl[res_index] > 0) ? tbl[res_index] - 1 : 0;
        end
        if (res_valid && res_mispredict) begin
            ghr1 = (int'(res_ghr) * 2 + int'(res_taken)) % 4;
            ghr0 = ghr1;
        end else if (pred_valid && !stall) begin
            ghr1 = (ghr1 * 2 + pt1) % 4;
            ghr0 = (ghr0 * 2 + pt0) % 4;
        end
    endtask

    // Inputs are set before calling; check before the edge, then advance the model.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; pred_valid = 0; res_valid = 0; res_taken = 0; res_mispredict = 0;
        res_index = 0; res_ghr = 0;
    endtask

    task automatic sweep_and_read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            pc = $urandom;
            step();
        end
        chk({tag, "_ready_up"}, bus1.ready, 1'b1);
        pc = 0;
        for (int i = 0; i < 16; i++) begin
            pc = 32'(i * 4);
            #1;
            chk({tag, "_entry_init"}, bus1.pred_count, 2'd1);
            step();
        end
    endtask

    int up_exp [4] = '{2, 3, 3, 3};
    int dn_exp [4] = '{2, 1, 0, 0};

    initial begin
        model_reset();
        #2;
        chk("rst_ready", bus1.ready, 1'b0);
        chk("rst_taken", bus1.pred_taken, 1'b0);
        chk("rst_count", bus1.pred_count, 2'd1);
        chk("rst_index", bus1.pred_index, 4'd0);
        chk("rst_ghr", bus1.pred_ghr, 2'd0);
        @(posedge clk); #1;
        rst_n = 1;
        sweep_and_read_all("sweep1");

        // Saturation at index 5, read through pc=0x14 with GHR=0
        pc = 32'h14; res_valid = 1; res_index = 5; res_taken = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("sat_up", bus1.pred_count, up_exp[k]);
        end
        res_taken = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("sat_down", bus1.pred_count, dn_exp[k]);
        end

        // Speculative advance then stall
        res_valid = 1; res_index = 3; res_taken = 1; pc = 32'h0C;
        step();
        res_valid = 0; pred_valid = 1;
        chk("spec_pred_taken", bus1.pred_taken, 1'b1);
        step();
        chk("spec_ghr_adv", bus1.pred_ghr, 2'd1);
        stall = 1;
        step();
        chk("stall_ghr_hold", bus1.pred_ghr, 2'd1);
        stall = 0;

        // Repair beats speculative advance
        res_valid = 1; res_mispredict = 1; res_ghr = 2'b10; res_taken = 1; res_index = 9;
        step();
        chk("repair_ghr", bus1.pred_ghr, 2'b01);

        // Hash check with GHR=11
        pred_valid = 0; res_ghr = 2'b01;
        step();
        idle_inputs();
        pc = 32'h14;
        #1;
        chk("hash_ghr", bus1.pred_ghr, 2'b11);
        chk("hash_xor_index", bus1.pred_index, 4'd6);
        chk("hash_cat_index", bus0.pred_index, 4'b0111);
        step();

        for (int n = 0; n < 300; n++) begin
            pc = $urandom;
            stall = 1'($urandom_range(0, 3) == 0);
            pred_valid = 1'($urandom);
            res_valid = 1'($urandom);
            res_taken = 1'($urandom);
            res_mispredict = 1'($urandom_range(0, 3) == 0);
            res_index = 4'($urandom);
            res_ghr = 2'($urandom);
            step();
        end

        // Async reset between edges with a nonzero GHR
        idle_inputs();
        res_valid = 1; res_mispredict = 1; res_ghr = 2'b01; res_taken = 1; res_index = 2;
        step();
        idle_inputs();
        chk("pre_async_ghr", bus1.pred_ghr, 2'b11);
        #3;
        rst_n = 0;
        #1;
        chk("async_ready", bus1.ready, 1'b0);
        chk("async_ghr_out", bus1.pred_ghr, 2'd0);
        chk("async_ghr_reg", u_dut1.ghr, 2'd0);
        chk("async_ptr_reg", u_dut1.ptr, 4'd0);
        chk("async_taken", bus1.pred_taken, 1'b0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        sweep_and_read_all("sweep2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
